// File: rtl/core_quant_pkg.sv
// rtl/core_quant_pkg.sv - widths, saturation bounds and the round/shift/saturate helper
package core_quant_pkg;

  localparam int IDATA_BIT = 16;
  localparam int ODATA_BIT = 8;
  localparam int SCALE_BIT = 8;
  localparam int SHIFT_BIT = 5;
  localparam int PROD_BIT  = IDATA_BIT + SCALE_BIT + 2;

  localparam logic signed [ODATA_BIT-1:0] OMAX = {1'b0, {(ODATA_BIT-1){1'b1}}};
  localparam logic signed [ODATA_BIT-1:0] OMIN = {1'b1, {(ODATA_BIT-1){1'b0}}};

  // Round half toward +inf in PROD_BIT+1 bits, add zero-point, clip to output range.
  function automatic logic signed [ODATA_BIT-1:0] round_shift_sat(
    input logic signed [PROD_BIT-1:0]  prod,
    input logic        [SHIFT_BIT-1:0] shift,
    input logic signed [ODATA_BIT-1:0] zp
  );
    logic signed [PROD_BIT:0]   ext;
    logic signed [PROD_BIT:0]   rnd;
    logic signed [PROD_BIT:0]   r;
    logic signed [PROD_BIT+1:0] v;
    ext = {prod[PROD_BIT-1], prod};
    rnd = '0;
    if (shift == '0) begin
      r = ext;
    end else begin
      rnd = $signed({{PROD_BIT{1'b0}}, 1'b1} << (shift - 1'b1));
      r   = (ext + rnd) >>> shift;
    end
    v = {r[PROD_BIT], r} + {{(PROD_BIT+2-ODATA_BIT){zp[ODATA_BIT-1]}}, zp};
    if (v > OMAX)      return OMAX;
    else if (v < OMIN) return OMIN;
    else               return v[ODATA_BIT-1:0];
  endfunction

endpackage

// File: rtl/core_quant_fifo.sv
// rtl/core_quant_fifo.sv - first-word-fall-through FIFO; write while full is accepted only with a same-cycle pop
module core_quant_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign dout  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/core_quant.sv
// rtl/core_quant.sv - bias/scale/round/zero-point/saturate requantizer with non-stalling pipeline and output FIFO
module core_quant
  import core_quant_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [IDATA_BIT-1:0] cfg_quant_bias,
  input  logic [SCALE_BIT-1:0] cfg_quant_scale,
  input  logic [SHIFT_BIT-1:0] cfg_quant_shift,
  input  logic [ODATA_BIT-1:0] cfg_quant_zp,
  input  logic                 cfg_ovf_clr,
  input  logic [IDATA_BIT-1:0] idata,
  input  logic                 idata_valid,
  output logic [ODATA_BIT-1:0] odata,
  output logic                 odata_valid,
  input  logic                 odata_ready,
  output logic                 ovf_flag
);

  logic                        v1, v2, v3;
  logic signed [IDATA_BIT:0]   sum1;
  logic signed [IDATA_BIT:0]   sum_next;
  logic signed [PROD_BIT-1:0]  prod2;
  logic signed [PROD_BIT-1:0]  sum_ext;
  logic signed [PROD_BIT-1:0]  scl_ext;
  logic signed [ODATA_BIT-1:0] q3;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        pop;
  logic                        drop;

  assign sum_next = $signed({idata[IDATA_BIT-1], idata})
                  + $signed({cfg_quant_bias[IDATA_BIT-1], cfg_quant_bias});
  assign sum_ext  = {{(PROD_BIT-IDATA_BIT-1){sum1[IDATA_BIT]}}, sum1};
  assign scl_ext  = {{(PROD_BIT-SCALE_BIT){1'b0}}, cfg_quant_scale};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      v3    <= 1'b0;
      sum1  <= '0;
      prod2 <= '0;
      q3    <= '0;
    end else begin
      v1 <= idata_valid;
      v2 <= v1;
      v3 <= v2;
      if (idata_valid) sum1  <= sum_next;
      if (v1)          prod2 <= sum_ext * scl_ext;
      if (v2)          q3    <= round_shift_sat(prod2, cfg_quant_shift, cfg_quant_zp);
    end
  end

  assign odata_valid = !fifo_empty;
  assign pop         = odata_valid && odata_ready;
  // Upstream cannot be stalled, so a full FIFO without a pop loses the result.
  assign drop        = v3 && fifo_full && !pop;

  core_quant_fifo #(
    .WIDTH (ODATA_BIT),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (v3),
    .din   (q3),
    .pop   (pop),
    .dout  (odata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)            ovf_flag <= 1'b0;
    else if (drop)        ovf_flag <= 1'b1;
    else if (cfg_ovf_clr) ovf_flag <= 1'b0;
  end

endmodule

// File: doc/core_quant.md
Name: core_quant

Overview:
- Requantization stage directly downstream of the accumulator.
- Takes each signed 16-bit accumulated partial sum and applies bias, unsigned scale, rounding right shift, zero-point and saturation to produce a signed 8-bit activation.
- The accumulator has no backpressure, so results are buffered in a small FIFO with ready/valid toward the consumer. Overflow is flagged, never stalled.

Parameters:
- IDATA_BIT, 16, width of signed input psum (accumulator output width).
- ODATA_BIT, 8, width of signed quantized output.
- SCALE_BIT, 8, width of unsigned scale multiplier.
- SHIFT_BIT, 5, width of right-shift amount.
- FIFO_DEPTH, 4, output buffer entries (power of two, >=2).

Ports:
- clk  in  1  clock
- rstn  in  1  reset
- cfg_quant_bias  in  IDATA_BIT  signed bias added before scaling
- cfg_quant_scale  in  SCALE_BIT  unsigned multiplier
- cfg_quant_shift  in  SHIFT_BIT  arithmetic right shift amount
- cfg_quant_zp  in  ODATA_BIT  signed zero-point added after shift
- cfg_ovf_clr  in  1  synchronous clear of ovf_flag
- idata  in  IDATA_BIT  signed psum from accumulator
- idata_valid  in  1  single-cycle qualifier; no ready returned upstream
- odata  out  ODATA_BIT  quantized result, head of FIFO
- odata_valid  out  1  FIFO non-empty
- odata_ready  in  1  consumer accepts odata this cycle
- ovf_flag  out  1  sticky: a result was dropped because the FIFO was full

Behaviour:
- Reset: rstn is asynchronous, active-low; clock is clk. On reset all pipeline valids = 0, FIFO empty, odata = 0, odata_valid = 0, ovf_flag = 0.
- Pipeline: three register stages, never stalls. A new sample may be accepted every cycle.
  - S1 (edge after idata_valid): sum = idata + bias, IDATA_BIT+1 bits signed, no overflow possible.
  - S2: prod = sum * {0,scale}, IDATA_BIT+SCALE_BIT+2 bits signed, exact.
  - S3: rounded value and FIFO write.
    - shift == 0: r = prod.
    - Otherwise: r = (prod + 2^(shift-1)) >>> shift (round half up toward +inf), computed in prod width + 1.
    - Then v = r + sign-extended zp.
    - Clip v to [-2^(ODATA_BIT-1), 2^(ODATA_BIT-1)-1] and write the clipped value to the FIFO.
- Latency: idata_valid at edge N -> FIFO write at edge N+3. If the FIFO was empty, odata_valid = 1 with correct odata after edge N+3. No empty-FIFO bypass.
- Config timing: cfg_* must be held stable while any pipeline stage is valid. Each field is used combinationally at its stage and is not shadowed.
- FIFO: first-word-fall-through, in-order.
  - Pop when odata_valid && odata_ready.
  - odata_ready while empty has no effect.
  - Write while full and no pop in the same cycle: the new result is dropped, the FIFO contents are unchanged, and ovf_flag is set at that edge.
  - Write while full with a simultaneous pop: accepted, count unchanged, no drop.
  - Simultaneous write and pop at any other occupancy: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH. Occupancy counter is log2(FIFO_DEPTH)+1 bits.
- ovf_flag: cleared by cfg_ovf_clr at the next edge. If set and clear occur in the same cycle, set wins.
- Reset mid-operation: in-flight pipeline results and FIFO contents are discarded. The first valid input after reset deasserts follows the normal latency.

Decomposition:
- Package core_quant_pkg holds:
  - width constants: psum, output, scale, shift;
  - derived product width;
  - saturation bound constants;
  - a rounding-shift-saturate function shared with the reference model.
- One sub-module: core_quant_fifo, a parameterized FWFT FIFO (push, pop, full, empty, dout).
- Arithmetic stays in core_quant.

Test Plan:
- Identity: bias=0, scale=1, shift=0, zp=0; idata=100 at edge N -> odata=100, odata_valid rises after edge N+3; idata=-7 -> -7.
- Rounding: scale=3, shift=4, bias=0, zp=0; idata=200 -> 38; idata=-200 -> -37 (-37.5 rounds up); idata=8, scale=1, shift=4 -> 1; idata=7 -> 0.
- Bias/zp/saturation:
  - bias=-50, zp=5, scale=1, shift=0: idata=50 -> 5.
  - idata=1000, scale=3, shift=4 -> 127.
  - idata=-32768, scale=255, shift=0 -> -128.
- Back-to-back throughput: 8 consecutive valid inputs 1..8 with odata_ready=1, identity config -> outputs 1..8 on 8 consecutive cycles, no gaps, ovf_flag=0.
- Overflow: odata_ready=0, six inputs 1..6 -> FIFO holds 1..4, ovf_flag=1 after the 5th write edge. Then odata_ready=1 drains 1,2,3,4 and odata_valid falls. cfg_ovf_clr pulse -> ovf_flag=0.
- Full with simultaneous pop: FIFO holds 4 entries, ready=1 while a write arrives -> no drop, ovf_flag stays 0, order preserved. Separately, assert rstn low with 2 entries queued and 2 in flight -> odata_valid=0 immediately, nothing emerges afterwards.
